// File: rtl/mini_core_if.sv
// Instruction-fetch front end: PC sequencing, synchronous I_MEM handshake and the
// Q101H instruction slot with stall hold and redirect/reset kill.
package mini_core_if_pkg;
   typedef struct packed {
      logic SelNextPcAluOutQ102H;
   } t_ctrl_if;

   localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

module mini_core_if
   import mini_core_if_pkg::*;
#(
   parameter int          I_MEM_ADRS_MSB = 15,
   parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
   input  logic                      Clock,
   input  logic                      Rst,
   input  logic                      ReadyQ100H,
   input  t_ctrl_if                  CtrlIf,
   input  logic [31:0]               AluOutQ102H,
   input  logic [31:0]               IMemRdDataQ101H,
   output logic [31:0]               PcQ100H,
   output logic [I_MEM_ADRS_MSB:0]   IMemAdrsQ100H,
   output logic                      IMemRdEnQ100H,
   output logic [31:0]               PcQ101H,
   output logic [31:0]               InstructionQ101H,
   output logic                      ValidQ101H
);

   logic        redirect;
   logic        advance;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] pc101_q,      pc101_d;
   logic        valid_q,      valid_d;
   logic        kill_q,       kill_d;
   logic        hold_vld_q,   hold_vld_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic        unused_alu_lsb;

   assign redirect       = CtrlIf.SelNextPcAluOutQ102H;
   assign advance        = ReadyQ100H | redirect;
   assign unused_alu_lsb = ^AluOutQ102H[1:0];

   // Read enable follows reset directly so RESET_PC is fetched in the very first cycle.
   assign IMemRdEnQ100H = Rst;
   assign PcQ100H       = pc_q;
   assign IMemAdrsQ100H = pc_q[I_MEM_ADRS_MSB:0];
   assign PcQ101H       = pc101_q;
   assign ValidQ101H    = valid_q;

   always_comb begin
      InstructionQ101H = IMemRdDataQ101H;
      if (kill_q) begin
         InstructionQ101H = NOP;
      end else if (hold_vld_q) begin
         InstructionQ101H = hold_instr_q;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      pc101_d      = pc101_q;
      valid_d      = valid_q;
      kill_d       = kill_q;
      hold_vld_d   = hold_vld_q;
      hold_instr_d = hold_instr_q;

      if (redirect) begin
         pc_d = {AluOutQ102H[31:2], 2'b00};
      end else if (ReadyQ100H) begin
         pc_d = pc_q + 32'd4;
      end

      if (advance) begin
         pc101_d    = pc_q;
         valid_d    = ~redirect;
         kill_d     = redirect;
         hold_vld_d = 1'b0;
      end else if (!hold_vld_q) begin
         // Memory keeps re-reading the stalled Q100H address, so the Q101H word is parked here.
         hold_instr_d = InstructionQ101H;
         hold_vld_d   = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         pc_q         <= RESET_PC;
         pc101_q      <= RESET_PC;
         valid_q      <= 1'b0;
         kill_q       <= 1'b1;
         hold_vld_q   <= 1'b0;
         hold_instr_q <= NOP;
      end else begin
         pc_q         <= pc_d;
         pc101_q      <= pc101_d;
         valid_q      <= valid_d;
         kill_q       <= kill_d;
         hold_vld_q   <= hold_vld_d;
         hold_instr_q <= hold_instr_d;
      end
   end

endmodule

// File: tb/tb_mini_core_if.sv
// Bench for mini_core_if: table of per-cycle stimulus with hand-derived expected fetch
// outputs fed through a scoreboard queue, plus reset sequences around stall and hold.
module tb_mini_core_if;
   import mini_core_if_pkg::*;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] pc101;
      logic [31:0] instr;
      logic        vld;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Rst   = 1'b0;
   logic        ReadyQ100H = 1'b0;
   t_ctrl_if    CtrlIf;
   logic [31:0] AluOutQ102H = 32'h0;
   logic [31:0] IMemRdDataQ101H = 32'h0;
   logic [31:0] PcQ100H;
   logic [15:0] IMemAdrsQ100H;
   logic        IMemRdEnQ100H;
   logic [31:0] PcQ101H;
   logic [31:0] InstructionQ101H;
   logic        ValidQ101H;

   int n_pass  = 0;
   int n_total = 0;

   vec_t vecs[$];
   vec_t sb[$];

   mini_core_if #(.I_MEM_ADRS_MSB(15), .RESET_PC(32'h0000_0000)) dut (
      .Clock            (Clock),
      .Rst              (Rst),
      .ReadyQ100H       (ReadyQ100H),
      .CtrlIf           (CtrlIf),
      .AluOutQ102H      (AluOutQ102H),
      .IMemRdDataQ101H  (IMemRdDataQ101H),
      .PcQ100H          (PcQ100H),
      .IMemAdrsQ100H    (IMemAdrsQ100H),
      .IMemRdEnQ100H    (IMemRdEnQ100H),
      .PcQ101H          (PcQ101H),
      .InstructionQ101H (InstructionQ101H),
      .ValidQ101H       (ValidQ101H)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return 32'hA500_0000 | {16'h0000, a[15:0]};
   endfunction

   always @(posedge Clock) begin
      if (IMemRdEnQ100H) IMemRdDataQ101H <= memw({16'h0000, IMemAdrsQ100H});
   end

   function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [31:0] pc101,
                               input logic [31:0] instr, input logic vld);
      vec_t v;
      v.rdy = rdy; v.redir = redir; v.alu = alu;
      v.pc = pc; v.pc101 = pc101; v.instr = instr; v.vld = vld;
      return v;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk32({tag, " pc100"}, PcQ100H, 32'h0);
      chk32({tag, " pc101"}, PcQ101H, 32'h0);
      chk32({tag, " adrs"},  {16'h0, IMemAdrsQ100H}, 32'h0);
      chk32({tag, " rden"},  {31'h0, IMemRdEnQ100H}, 32'h0);
      chk32({tag, " valid"}, {31'h0, ValidQ101H}, 32'h0);
      chk32({tag, " instr"}, InstructionQ101H, NOP_W);
   endtask

   initial begin
      CtrlIf = '0;

      // expected columns describe the cycle after the row's inputs are applied
      vecs.push_back(mk(1, 0, 0,            32'h004,      32'h000,      memw(32'h000), 1));
      vecs.push_back(mk(1, 0, 0,            32'h008,      32'h004,      memw(32'h004), 1));
      vecs.push_back(mk(1, 0, 0,            32'h00C,      32'h008,      memw(32'h008), 1));
      vecs.push_back(mk(1, 0, 0,            32'h010,      32'h00C,      memw(32'h00C), 1));
      vecs.push_back(mk(0, 0, 0,            32'h010,      32'h00C,      memw(32'h00C), 1));
      vecs.push_back(mk(0, 0, 0,            32'h010,      32'h00C,      memw(32'h00C), 1));
      vecs.push_back(mk(0, 0, 0,            32'h010,      32'h00C,      memw(32'h00C), 1));
      vecs.push_back(mk(1, 0, 0,            32'h014,      32'h010,      memw(32'h010), 1));
      vecs.push_back(mk(1, 0, 0,            32'h018,      32'h014,      memw(32'h014), 1));
      vecs.push_back(mk(1, 0, 0,            32'h01C,      32'h018,      memw(32'h018), 1));
      vecs.push_back(mk(1, 0, 0,            32'h020,      32'h01C,      memw(32'h01C), 1));
      vecs.push_back(mk(1, 1, 32'h203,      32'h200,      32'h020,      NOP_W,         0));
      vecs.push_back(mk(1, 0, 0,            32'h204,      32'h200,      memw(32'h200), 1));
      vecs.push_back(mk(1, 0, 0,            32'h208,      32'h204,      memw(32'h204), 1));
      vecs.push_back(mk(0, 1, 32'h400,      32'h400,      32'h208,      NOP_W,         0));
      vecs.push_back(mk(0, 0, 0,            32'h400,      32'h208,      NOP_W,         0));
      vecs.push_back(mk(0, 0, 0,            32'h400,      32'h208,      NOP_W,         0));
      vecs.push_back(mk(1, 0, 0,            32'h404,      32'h400,      memw(32'h400), 1));
      vecs.push_back(mk(1, 1, 32'h600,      32'h600,      32'h404,      NOP_W,         0));
      vecs.push_back(mk(1, 1, 32'h802,      32'h800,      32'h600,      NOP_W,         0));
      vecs.push_back(mk(1, 0, 0,            32'h804,      32'h800,      memw(32'h800), 1));
      vecs.push_back(mk(0, 0, 0,            32'h804,      32'h800,      memw(32'h800), 1));
      vecs.push_back(mk(0, 1, 32'h101,      32'h100,      32'h804,      NOP_W,         0));
      vecs.push_back(mk(1, 0, 0,            32'h104,      32'h100,      memw(32'h100), 1));
      vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h104,     NOP_W,         0));
      vecs.push_back(mk(1, 0, 0,            32'h000,      32'hFFFF_FFFC, memw(32'hFFFC), 1));
      vecs.push_back(mk(1, 0, 0,            32'h004,      32'h000,      memw(32'h000), 1));
      vecs.push_back(mk(0, 0, 0,            32'h004,      32'h000,      memw(32'h000), 1));
      vecs.push_back(mk(1, 0, 0,            32'h008,      32'h004,      memw(32'h004), 1));
      vecs.push_back(mk(0, 0, 0,            32'h008,      32'h004,      memw(32'h004), 1));

      #12;
      chk_reset("in_reset");

      @(negedge Clock);
      Rst = 1'b1;
      #1;
      chk32("rel pc100", PcQ100H, 32'h0);
      chk32("rel rden",  {31'h0, IMemRdEnQ100H}, 32'h1);
      chk32("rel valid", {31'h0, ValidQ101H}, 32'h0);
      chk32("rel instr", InstructionQ101H, NOP_W);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t e;
         ReadyQ100H = vecs[i].rdy;
         CtrlIf.SelNextPcAluOutQ102H = vecs[i].redir;
         AluOutQ102H = vecs[i].redir ? vecs[i].alu : 32'hDEAD_BEE0;
         sb.push_back(vecs[i]);
         @(negedge Clock);
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL row%0d scoreboard: got empty queue expected one entry", i);
         end else begin
            e = sb.pop_front();
            chk32($sformatf("row%0d pc100", i), PcQ100H, e.pc);
            chk32($sformatf("row%0d adrs", i), {16'h0, IMemAdrsQ100H}, {16'h0, e.pc[15:0]});
            chk32($sformatf("row%0d rden", i), {31'h0, IMemRdEnQ100H}, 32'h1);
            chk32($sformatf("row%0d pc101", i), PcQ101H, e.pc101);
            chk32($sformatf("row%0d instr", i), InstructionQ101H, e.instr);
            chk32($sformatf("row%0d valid", i), {31'h0, ValidQ101H}, {31'h0, e.vld});
         end
      end

      // last row left the core stalled with a held instruction; reset lands mid-cycle
      #2;
      Rst = 1'b0;
      #1;
      chk_reset("mid_stall_rst");

      @(negedge Clock);
      Rst = 1'b1;
      ReadyQ100H = 1'b1;
      CtrlIf.SelNextPcAluOutQ102H = 1'b0;
      #1;
      chk32("rerel pc100", PcQ100H, 32'h0);
      chk32("rerel instr", InstructionQ101H, NOP_W);
      chk32("rerel valid", {31'h0, ValidQ101H}, 32'h0);
      @(negedge Clock);
      chk32("rerel2 pc100", PcQ100H, 32'h4);
      chk32("rerel2 pc101", PcQ101H, 32'h0);
      chk32("rerel2 instr", InstructionQ101H, memw(32'h0));
      chk32("rerel2 valid", {31'h0, ValidQ101H}, 32'h1);

      // reset while a redirect kill is pending must not leave an extra bubble behind
      CtrlIf.SelNextPcAluOutQ102H = 1'b1;
      AluOutQ102H = 32'h300;
      @(negedge Clock);
      CtrlIf.SelNextPcAluOutQ102H = 1'b0;
      chk32("redir_pre pc100", PcQ100H, 32'h300);
      #2;
      Rst = 1'b0;
      #1;
      chk_reset("mid_redir_rst");
      @(negedge Clock);
      Rst = 1'b1;
      @(negedge Clock);
      chk32("redir_rel pc100", PcQ100H, 32'h4);
      chk32("redir_rel instr", InstructionQ101H, memw(32'h0));
      chk32("redir_rel valid", {31'h0, ValidQ101H}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
